// File: rtl/freq_meter.sv
// Gated-count frequency meter.
// Counts rising edges of an asynchronous input over a fixed window of sysclk
// cycles. Once per window it publishes the count as packed BCD, along with a
// saturation flag and a one-cycle valid strobe.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_GATE  | window open: timer t steps 0..GATE_CYCLES-1, rises are counted
//   ST_LATCH | single dead cycle: publish result, clear accumulator and timer
module freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int DIGITS      = 6
) (
  input  logic                sysclk,
  input  logic                resetb,
  input  logic                sigin,
  output logic [4*DIGITS-1:0] freq_bcd,
  output logic                overflow,
  output logic                valid,
  output logic                gate_open
);

  localparam int            TW       = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST   = TW'(GATE_CYCLES - 1);
  localparam logic [0:0]    ST_GATE  = 1'b0;
  localparam logic [0:0]    ST_LATCH = 1'b1;

  logic                s0;
  logic                s1;
  logic                s2;
  logic                rise;
  logic [0:0]          state;
  logic [0:0]          state_nxt;
  logic [TW-1:0]       t;
  logic                t_last;
  logic [4*DIGITS-1:0] acc;
  logic [4*DIGITS-1:0] acc_inc;
  logic [DIGITS:0]     carry;
  logic                acc_full;
  logic                sticky;
  logic                in_gate;
  logic                in_latch;

  // Three-flop path for the asynchronous input. The flops reset to 0, so an
  // input that is already high at release shows up as one rising edge.
  always_ff @(posedge sysclk or negedge resetb) begin
    if (!resetb) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s0 <= sigin;
      s1 <= s0;
      s2 <= s1;
    end
  end

  assign rise     = s1 & ~s2;
  assign in_gate  = (state == ST_GATE);
  assign in_latch = (state == ST_LATCH);
  assign t_last   = (t == T_LAST);

  // Decimal ripple increment. carry[i] means digits below i are all 9, so
  // carry[DIGITS] marks an accumulator that is already at its maximum.
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] d;
    logic       nine;
    assign d            = acc[4*i +: 4];
    assign nine         = (d == 4'd9);
    assign carry[i+1]   = carry[i] & nine;
    assign acc_inc[4*i +: 4] = carry[i] ? (nine ? 4'd0 : d + 4'd1) : d;
  end
  assign acc_full = carry[DIGITS];

  // Next-state logic: the window closes on its last timer step, and the
  // latch state always lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_GATE:  if (t_last) state_nxt = ST_LATCH;
      default:  state_nxt = ST_GATE;
    endcase
  end

  // State register.
  always_ff @(posedge sysclk or negedge resetb) begin
    if (!resetb) state <= ST_GATE;
    else         state <= state_nxt;
  end

  // Gate timer counts up through the window. It holds at its last value
  // during the latch cycle and restarts from zero when the cycle ends.
  always_ff @(posedge sysclk or negedge resetb) begin
    if (!resetb) begin
      t <= '0;
    end else if (in_latch) begin
      t <= '0;
    end else if (!t_last) begin
      t <= t + TW'(1);
    end
  end

  // Edge accumulator with saturation. At all-9s, a further rise sets the
  // sticky bit instead of wrapping. Rises during the latch cycle are dropped.
  always_ff @(posedge sysclk or negedge resetb) begin
    if (!resetb) begin
      acc    <= '0;
      sticky <= 1'b0;
    end else if (in_latch) begin
      acc    <= '0;
      sticky <= 1'b0;
    end else if (in_gate && rise) begin
      if (acc_full) sticky <= 1'b1;
      else          acc    <= acc_inc;
    end
  end

  // Result registers and strobe. They update only on the edge that ends the
  // latch cycle and hold steady between updates.
  always_ff @(posedge sysclk or negedge resetb) begin
    if (!resetb) begin
      freq_bcd <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= in_latch;
      if (in_latch) begin
        freq_bcd <= acc;
        overflow <= sticky;
      end
    end
  end

  // gate_open is registered from the next state. It is low while in reset
  // and during latch cycles, and high from the first clock after release.
  always_ff @(posedge sysclk or negedge resetb) begin
    if (!resetb) gate_open <= 1'b0;
    else         gate_open <= (state_nxt == ST_GATE);
  end

endmodule

// File: tb/tb_freq_meter.sv
// Testbench for freq_meter. Three instances cover short and long windows and
// the 6- and 2-digit widths. Every strobe is checked against a window-count
// model built from the drive history.
`timescale 1ns/1ps
module tb_freq_meter;

  localparam int G_A = 100;  localparam int D_A = 6;
  localparam int G_B = 1000; localparam int D_B = 2;
  localparam int G_C = 1000; localparam int D_C = 6;
  localparam int NLVL = 4096;

  logic        sysclk = 1'b0;
  logic [2:0]  rb = 3'b000;
  logic [2:0]  sg = 3'b000;
  logic [23:0] bcd_a;  logic ovf_a, val_a, gate_a;
  logic [7:0]  bcd_b;  logic ovf_b, val_b, gate_b;
  logic [23:0] bcd_c;  logic ovf_c, val_c, gate_c;

  logic [23:0] obs_bcd;
  logic        obs_ovf, obs_valid, obs_gate;
  int          cur = 0;

  int          n_checks = 0;
  int          n_err = 0;
  bit          lvl [0:NLVL-1];
  logic [23:0] got_bcd [0:7];
  logic        got_ovf [0:7];
  int          nstrobe;

  typedef struct {
    int          sel;
    int          period;
    int          high;
    logic [23:0] bcd;
    logic        ovf;
  } vec_t;
  vec_t tbl [12];

  always #5 sysclk = ~sysclk;

  freq_meter #(.GATE_CYCLES(G_A), .DIGITS(D_A)) u_a (
    .sysclk(sysclk), .resetb(rb[0]), .sigin(sg[0]),
    .freq_bcd(bcd_a), .overflow(ovf_a), .valid(val_a), .gate_open(gate_a));
  freq_meter #(.GATE_CYCLES(G_B), .DIGITS(D_B)) u_b (
    .sysclk(sysclk), .resetb(rb[1]), .sigin(sg[1]),
    .freq_bcd(bcd_b), .overflow(ovf_b), .valid(val_b), .gate_open(gate_b));
  freq_meter #(.GATE_CYCLES(G_C), .DIGITS(D_C)) u_c (
    .sysclk(sysclk), .resetb(rb[2]), .sigin(sg[2]),
    .freq_bcd(bcd_c), .overflow(ovf_c), .valid(val_c), .gate_open(gate_c));

  always_comb begin
    obs_bcd = '0; obs_ovf = 1'b0; obs_valid = 1'b0; obs_gate = 1'b0;
    case (cur)
      0: begin obs_bcd = bcd_a;          obs_ovf = ovf_a; obs_valid = val_a; obs_gate = gate_a; end
      1: begin obs_bcd = {16'h0, bcd_b}; obs_ovf = ovf_b; obs_valid = val_b; obs_gate = gate_b; end
      default: begin obs_bcd = bcd_c;    obs_ovf = ovf_c; obs_valid = val_c; obs_gate = gate_c; end
    endcase
  end

  function automatic int gate_of(input int s);
    return (s == 0) ? G_A : ((s == 1) ? G_B : G_C);
  endfunction

  function automatic int dig_of(input int s);
    return (s == 0) ? D_A : ((s == 1) ? D_B : D_C);
  endfunction

  function automatic bit lv(input int i);
    return (i < 0) ? 1'b0 : lvl[i];
  endfunction

  // Reference model. An input level driven in cycle k appears as a rise in
  // cycle k+2. A window counts the rises that land in its GATE_CYCLES cycles.
  function automatic int win_count(input int g, input int w);
    int lo;
    int n;
    lo = w * (g + 1);
    n  = 0;
    for (int c = lo; c < lo + g; c++)
      if (lv(c - 2) && !lv(c - 3)) n++;
    return n;
  endfunction

  function automatic logic [23:0] to_bcd(input int n);
    logic [23:0] r;
    int          v;
    r = '0;
    v = n;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic gen_periodic(input int p, input int h);
    for (int i = 0; i < NLVL; i++)
      lvl[i] = (p == 0) ? 1'b1 : ((i % p) >= (p - h));
  endtask

  task automatic gen_rand(input int maxr, input bit start);
    bit l;
    int i;
    int len;
    l = start;
    i = 0;
    while (i < NLVL) begin
      len = $urandom_range(maxr, 2);
      for (int j = 0; j < len && i < NLVL; j++) begin
        lvl[i] = l;
        i++;
      end
      l = ~l;
    end
  endtask

  // Reset the selected instance for 'hold' cycles, then release it and drive
  // lvl[k] during cycle k. Every cycle is checked against the model.
  task automatic run(input int s, input int ncyc, input int hold);
    int          g, d, lim, n, w;
    logic [23:0] exp_bcd;
    logic        exp_ovf;
    logic        bad;
    g = gate_of(s);
    d = dig_of(s);
    lim = 1;
    repeat (d) lim = lim * 10;
    lim = lim - 1;
    cur = s;
    nstrobe = 0;
    for (int i = 0; i < 8; i++) begin got_bcd[i] = 24'hFFFFFF; got_ovf[i] = 1'bx; end
    exp_bcd = '0;
    exp_ovf = 1'b0;
    @(negedge sysclk);
    rb[s] = 1'b0;
    sg[s] = lvl[0];
    repeat (hold) begin
      @(negedge sysclk);
      chk("rst_freq_bcd", obs_bcd, 0);
      chk("rst_overflow", obs_ovf, 0);
      chk("rst_valid", obs_valid, 0);
      chk("rst_gate_open", obs_gate, 0);
    end
    rb[s] = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge sysclk);
      #1;
      sg[s] = lvl[k];
      if (k % (g + 1) == 0) begin
        w = k / (g + 1) - 1;
        n = win_count(g, w);
        exp_bcd = to_bcd((n < lim) ? n : lim);
        exp_ovf = (n > lim);
        chk("valid", obs_valid, 1);
        if (nstrobe < 8) begin
          got_bcd[nstrobe] = obs_bcd;
          got_ovf[nstrobe] = obs_ovf;
        end
        nstrobe++;
      end else begin
        chk("valid", obs_valid, 0);
      end
      chk("gate_open", obs_gate, (k % (g + 1)) != g);
      chk("freq_bcd", obs_bcd, exp_bcd);
      chk("overflow", obs_ovf, exp_ovf);
      bad = 1'b0;
      for (int i = 0; i < 6; i++) if (obs_bcd[4*i +: 4] > 4'd9) bad = 1'b1;
      chk("bcd_digit_range", bad, 0);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{2, 100, 50, 24'h000010, 1'b0};
    tbl[1]  = '{2,  10,  5, 24'h000100, 1'b0};
    tbl[2]  = '{2,   4,  2, 24'h000249, 1'b0};
    tbl[3]  = '{0,  10,  5, 24'h000010, 1'b0};
    tbl[4]  = '{0,  11,  2, 24'h000009, 1'b0};
    tbl[5]  = '{0,   5,  3, 24'h000020, 1'b0};
    tbl[6]  = '{1,   4,  2, 24'h000099, 1'b1};
    tbl[7]  = '{1,  40, 20, 24'h000025, 1'b0};
    tbl[8]  = '{1,  10,  5, 24'h000099, 1'b1};
    tbl[9]  = '{1,  11,  5, 24'h000091, 1'b0};
    tbl[10] = '{1,  10,  2, 24'h000099, 1'b0};
    tbl[11] = '{1,  10,  3, 24'h000099, 1'b1};

    for (int v = 0; v < 12; v++) begin
      gen_periodic(tbl[v].period, tbl[v].high);
      run(tbl[v].sel, 2 * (gate_of(tbl[v].sel) + 1) + 2, 2);
      chk($sformatf("tbl%0d_bcd", v), got_bcd[0], tbl[v].bcd);
      chk($sformatf("tbl%0d_ovf", v), got_ovf[0], tbl[v].ovf);
    end

    // Saturate first, then confirm that the sticky bit clears on the next window.
    for (int i = 0; i < NLVL; i++)
      lvl[i] = (i < 1001) ? ((i % 4) >= 2) : (((i - 1001) % 40) >= 20);
    run(1, 2 * 1001 + 2, 2);
    chk("sat_bcd", got_bcd[0], 24'h99);
    chk("sat_ovf", got_ovf[0], 1);
    chk("sat_clear_bcd", got_bcd[1], 24'h25);
    chk("sat_clear_ovf", got_ovf[1], 0);

    // A rise on t=99 is counted; a rise on the latch cycle is dropped.
    for (int i = 0; i < NLVL; i++)
      lvl[i] = (i >= 97 && i < 110) || (i >= 199);
    run(0, 3 * 101 + 1, 2);
    chk("dead_last_gate", got_bcd[0], 24'h1);
    chk("dead_latch", got_bcd[1], 24'h0);
    chk("dead_after", got_bcd[2], 24'h0);

    // An input stuck high from before release counts once.
    gen_periodic(0, 0);
    run(0, 3 * 101 + 1, 3);
    chk("stuck_first", got_bcd[0], 24'h1);
    chk("stuck_second", got_bcd[1], 24'h0);
    chk("stuck_third", got_bcd[2], 24'h0);

    // Reset at t=600 discards the partial window. The next strobe arrives a
    // full window later with a fresh count.
    gen_periodic(20, 10);
    run(2, 600, 2);
    chk("midrst_no_strobe", nstrobe, 0);
    run(2, 1001 + 5, 3);
    chk("midrst_strobes", nstrobe, 1);
    chk("midrst_bcd", got_bcd[0], 24'h50);
    chk("midrst_ovf", got_ovf[0], 0);

    // Randomised input phases, each at least 2 cycles long.
    for (int r = 0; r < 8; r++) begin
      gen_rand(2 + 3 * r, r[0]);
      run(0, 3 * 101 + 1, 2);
    end
    for (int r = 0; r < 3; r++) begin
      gen_rand((r == 2) ? 20 : 3 + r, r[0]);
      run(1, 2 * 1001 + 1, 2);
    end
    gen_rand(8, 1'b0);
    run(2, 2 * 1001 + 1, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
